// File: rtl/proc_seq_if.sv
// Stage-side bus of the processor sequencer: per-stage start/ready handshakes,
// per-stage memory requests and the single muxed memory port.
interface proc_seq_if #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_STAGES-1:0]            stg_start_o;
  logic [NUM_STAGES-1:0]            stg_ready_i;
  logic [NUM_STAGES-1:0]            stg_mem_ce_i;
  logic [NUM_STAGES-1:0]            stg_mem_we_i;
  logic [NUM_STAGES*ADDR_WIDTH-1:0] stg_mem_addr_i;
  logic [NUM_STAGES*4-1:0]          stg_mem_width_i;
  logic [NUM_STAGES*DATA_WIDTH-1:0] stg_mem_data_i;
  logic                             mem_ce_o;
  logic                             mem_we_o;
  logic [ADDR_WIDTH-1:0]            mem_addr_o;
  logic [3:0]                       mem_width_o;
  logic [DATA_WIDTH-1:0]            mem_data_o;

  // The sequencer drives stage starts and the shared memory port.
  modport master (
    output stg_start_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    input  stg_ready_i, stg_mem_ce_i, stg_mem_we_i, stg_mem_addr_i,
           stg_mem_width_i, stg_mem_data_i
  );

  // The stage engines and memory side see the mirror image.
  modport slave (
    input  stg_start_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    output stg_ready_i, stg_mem_ce_i, stg_mem_we_i, stg_mem_addr_i,
           stg_mem_width_i, stg_mem_data_i
  );
endinterface

// File: rtl/proc_seq.sv
// Packet sequencer: runs up to NUM_STAGES engines in order with a skip mask,
// a per-stage watchdog, a latency counter and a shared memory port mux.
module proc_seq #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TO_WIDTH   = 16,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [NUM_STAGES-1:0] skip_mask_i,
  input  logic [TO_WIDTH-1:0]   timeout_i,
  proc_seq_if.master            bus,
  output logic                  busy_o,
  output logic [SEL_WIDTH-1:0]  cur_stage_o,
  output logic                  ready_o,
  output logic                  error_o,
  output logic [SEL_WIDTH-1:0]  err_stage_o,
  output logic [31:0]           cycle_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;
  } pick_t;

  // Lowest unskipped stage, either anywhere or strictly after 'after'.
  function automatic pick_t next_stage(input logic [NUM_STAGES-1:0] mask,
                                       input logic [SEL_WIDTH-1:0]  after,
                                       input logic                  from_start);
    pick_t p;
    p = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (!mask[k] && (from_start || (SEL_WIDTH'(k) > after))) begin
        p.found = 1'b1;
        p.idx   = SEL_WIDTH'(k);
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
    logic [NUM_STAGES-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      v[k] = (SEL_WIDTH'(k) == idx);
    end
    return v;
  endfunction

  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [TO_WIDTH-1:0]   wd_q, wd_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [TO_WIDTH-1:0]   to_q, to_d;
  logic [NUM_STAGES-1:0] start_q, start_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
  logic [SEL_WIDTH-1:0]  err_stage_q, err_stage_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  ready_sel;
  pick_t                 pick;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      wd_q        <= '0;
      mask_q      <= '0;
      to_q        <= '0;
      start_q     <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      err_stage_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wd_q        <= wd_d;
      mask_q      <= mask_d;
      to_q        <= to_d;
      start_q     <= start_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      err_stage_q <= err_stage_d;
      cnt_q       <= cnt_d;
    end
  end

  // Only the selected stage's ready matters; the others are ignored.
  always_comb begin
    ready_sel = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (sel_q == SEL_WIDTH'(k)) ready_sel = bus.stg_ready_i[k];
    end
  end

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wd_d        = wd_q;
    mask_d      = mask_q;
    to_d        = to_q;
    start_d     = start_q;
    ready_d     = ready_q;
    error_d     = error_q;
    err_stage_d = err_stage_q;
    cnt_d       = cnt_q;
    pick        = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mask_d      = skip_mask_i;
          to_d        = timeout_i;
          ready_d     = 1'b0;
          error_d     = 1'b0;
          err_stage_d = '0;
          cnt_d       = '0;
          pick        = next_stage(skip_mask_i, '0, 1'b1);
          if (pick.found) begin
            start_d = onehot(pick.idx);
            sel_d   = pick.idx;
            wd_d    = '0;
            state_d = S_RUN;
          end else begin
            ready_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        if (ready_sel) begin
          // Successor start rises on the same edge the current one drops.
          pick = next_stage(mask_q, sel_q, 1'b0);
          if (pick.found) begin
            start_d = onehot(pick.idx);
            sel_d   = pick.idx;
            wd_d    = '0;
          end else begin
            start_d = '0;
            ready_d = 1'b1;
            state_d = S_DONE;
          end
        end else if ((to_q != '0) && (wd_q == to_q - 1'b1)) begin
          start_d     = '0;
          error_d     = 1'b1;
          err_stage_d = sel_q;
          ready_d     = 1'b1;
          state_d     = S_DONE;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_DONE: begin
        // A start held high from the previous packet must drop first.
        if (!start_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Shared memory port follows the registered selection, quiet outside RUN.
  always_comb begin
    bus.mem_ce_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_width_o = '0;
    bus.mem_data_o  = '0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (sel_q == SEL_WIDTH'(k)) begin
          bus.mem_ce_o    = bus.stg_mem_ce_i[k];
          bus.mem_we_o    = bus.stg_mem_we_i[k];
          bus.mem_addr_o  = bus.stg_mem_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          bus.mem_width_o = bus.stg_mem_width_i[k*4 +: 4];
          bus.mem_data_o  = bus.stg_mem_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign bus.stg_start_o = start_q;
  assign busy_o          = (state_q == S_RUN);
  assign cur_stage_o     = sel_q;
  assign ready_o         = ready_q;
  assign error_o         = error_q;
  assign err_stage_o     = err_stage_q;
  assign cycle_cnt_o     = cnt_q;

endmodule

// File: tb/tb_proc_seq.sv
// Randomised bench for proc_seq: emulated stage engines with per-stage latency,
// checked cycle by cycle against a timeline model built from the stage rules.
module tb_proc_seq;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [NS-1:0] skip_mask_i;
  logic [TW-1:0] timeout_i;
  logic          busy_o;
  logic [SW-1:0] cur_stage_o;
  logic          ready_o;
  logic          error_o;
  logic [SW-1:0] err_stage_o;
  logic [31:0]   cycle_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int lat[NS];   // cycles from a stage's start to its ready; 0 = never ready
  int age[NS];
  logic [NS-1:0] exp_oh[$];

  proc_seq_if #(.NUM_STAGES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  proc_seq #(
    .NUM_STAGES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TO_WIDTH(TW), .SEL_WIDTH(SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .skip_mask_i (skip_mask_i),
    .timeout_i   (timeout_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .cur_stage_o (cur_stage_o),
    .ready_o     (ready_o),
    .error_o     (error_o),
    .err_stage_o (err_stage_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stage engines: ready after 'lat' cycles of start; idle stages toggle ready
  // randomly, and every stage presents random memory traffic each cycle.
  initial begin
    bus.stg_ready_i     = '0;
    bus.stg_mem_ce_i    = '0;
    bus.stg_mem_we_i    = '0;
    bus.stg_mem_addr_i  = '0;
    bus.stg_mem_width_i = '0;
    bus.stg_mem_data_i  = '0;
    for (int k = 0; k < NS; k++) age[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NS; k++) begin
        if (bus.stg_start_o[k]) begin
          age[k]++;
          bus.stg_ready_i[k] = (lat[k] != 0) && (age[k] == lat[k]);
        end else begin
          age[k] = 0;
          bus.stg_ready_i[k] = 1'($urandom_range(0, 1));
        end
        bus.stg_mem_addr_i[k*AW +: AW] = $urandom;
        bus.stg_mem_data_i[k*DW +: DW] = $urandom;
        bus.stg_mem_width_i[k*4 +: 4]  = 4'($urandom);
      end
      bus.stg_mem_ce_i = NS'($urandom);
      bus.stg_mem_we_i = NS'($urandom);
    end
  end

  // Model: walk the unskipped stages in order; each occupies lat cycles, or
  // 'to' cycles and aborts if it would not be ready within the timeout.
  task automatic run_pkt(input logic [NS-1:0] mask, input logic [TW-1:0] to, input int hold);
    logic err;
    int   es;
    int   cnt;
    int   idx;
    err = 1'b0;
    es  = 0;
    exp_oh.delete();
    for (int k = 0; k < NS; k++) begin
      int dur;
      if (!mask[k] && !err) begin
        if (lat[k] != 0 && (to == 0 || lat[k] <= int'(to))) begin
          dur = lat[k];
        end else begin
          dur = int'(to);
          err = 1'b1;
          es  = k;
        end
        repeat (dur) exp_oh.push_back(NS'(1) << k);
      end
    end
    cnt = exp_oh.size();

    @(posedge clk);
    #1;
    start_i     = 1'b1;
    skip_mask_i = mask;
    timeout_i   = to;
    @(posedge clk);  // acceptance edge

    for (int c = 0; c < cnt; c++) begin
      @(negedge clk);
      idx = 0;
      for (int k = 0; k < NS; k++) if (exp_oh[c][k]) idx = k;
      check("stg_start", bus.stg_start_o, exp_oh[c]);
      check("busy_run", busy_o, 1);
      check("cur_stage", cur_stage_o, idx);
      check("mem_ctl", {bus.mem_ce_o, bus.mem_we_o, bus.mem_width_o},
            {bus.stg_mem_ce_i[idx], bus.stg_mem_we_i[idx], bus.stg_mem_width_i[idx*4 +: 4]});
      check("mem_addr", bus.mem_addr_o, bus.stg_mem_addr_i[idx*AW +: AW]);
      check("mem_data", bus.mem_data_o, bus.stg_mem_data_i[idx*DW +: DW]);
      if (c == 0) begin
        check("ready_cleared", ready_o, 0);
        check("error_cleared", error_o, 0);
      end
    end

    @(negedge clk);
    check("ready", ready_o, 1);
    check("error", error_o, err);
    check("err_stage", err_stage_o, err ? es : 0);
    check("cycle_cnt", cycle_cnt_o, cnt);
    check("start_done", bus.stg_start_o, 0);
    check("busy_done", busy_o, 0);
    check("mem_quiet", {bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o}, 0);

    // start held high in DONE must not retrigger
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("no_retrigger", {busy_o, bus.stg_start_o, ready_o}, 1);
    end

    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_hold_idle", ready_o, 1);
    check("cnt_hold_idle", cycle_cnt_o, cnt);
  endtask

  initial begin
    logic [NS-1:0] m;
    logic [TW-1:0] to;
    rst         = 1'b0;
    start_i     = 1'b0;
    skip_mask_i = '0;
    timeout_i   = '0;
    for (int k = 0; k < NS; k++) lat[k] = 1;

    repeat (2) @(negedge clk);
    check("rst_outputs", {busy_o, ready_o, error_o, err_stage_o, cur_stage_o, bus.stg_start_o}, 0);
    check("rst_cnt", cycle_cnt_o, 0);
    check("rst_mem", {bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o}, 0);
    rst = 1'b1;

    // Directed cases
    lat = '{5, 5, 5};
    run_pkt(3'b000, 16'd0, 1);
    check("plan_cnt15", cycle_cnt_o, 15);
    lat = '{3, 4, 6};
    run_pkt(3'b010, 16'd0, 0);
    lat = '{5, 0, 5};
    run_pkt(3'b000, 16'd8, 0);
    check("plan_err_stage1", {error_o, err_stage_o}, {1'b1, 3'd1});
    lat = '{4, 2, 3};
    run_pkt(3'b000, 16'd4, 0);
    lat = '{5, 5, 5};
    run_pkt(3'b111, 16'd0, 3);
    check("plan_skipall_cnt", cycle_cnt_o, 0);
    lat = '{1, 1, 1};
    run_pkt(3'b000, 16'd1, 0);

    // Randomised packets
    for (int p = 0; p < 40; p++) begin
      m = NS'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      if ($urandom_range(0, 9) == 0) m = '1;
      to = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 10));
      for (int k = 0; k < NS; k++) begin
        lat[k] = $urandom_range(1, 10);
        if (to != 0 && $urandom_range(0, 5) == 0) lat[k] = 0;
      end
      run_pkt(m, to, $urandom_range(0, 3));
    end

    // Reset while stage 1 is active
    lat = '{3, 0, 2};
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    skip_mask_i = '0;
    timeout_i   = '0;
    @(posedge clk);
    repeat (5) @(negedge clk);
    check("pre_reset_stage1", bus.stg_start_o, 3'b010);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outputs", {busy_o, ready_o, error_o, err_stage_o, cur_stage_o, bus.stg_start_o}, 0);
    check("async_rst_cnt", cycle_cnt_o, 0);
    check("async_rst_mem", {bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o}, 0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    lat = '{2, 3, 2};
    run_pkt(3'b000, 16'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/proc_seq.md
Name: proc_seq

Overview:
- Parametrised successor to the fixed three-stage processor controller.
- Sequences NUM_STAGES pipeline engines (parser, matcher, executor, and later additions) one after another, each through a start/ready handshake.
- Grants the single shared memory port to the active stage only.
- Adds a per-packet stage-skip mask, a per-stage watchdog timeout with error reporting, and a packet latency counter.

Parameters:
NUM_STAGES, 3, number of sequenced stages (2..8); stage 0 runs first
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, memory data width
TO_WIDTH, 16, watchdog timeout counter width
SEL_WIDTH, 3, width of stage index outputs (>= clog2(NUM_STAGES))

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start_i  in  1  level request to process one packet
skip_mask_i  in  NUM_STAGES  bit k=1 skips stage k; sampled at start acceptance
timeout_i  in  TO_WIDTH  max cycles per stage; 0 disables watchdog; sampled at start acceptance
stg_start_o  out  NUM_STAGES  one-hot start level to each stage
stg_ready_i  in  NUM_STAGES  ready level from each stage
stg_mem_ce_i  in  NUM_STAGES  per-stage memory chip enable
stg_mem_we_i  in  NUM_STAGES  per-stage write enable
stg_mem_addr_i  in  NUM_STAGES*ADDR_WIDTH  per-stage address, stage k at slice k
stg_mem_width_i  in  NUM_STAGES*4  per-stage byte width
stg_mem_data_i  in  NUM_STAGES*DATA_WIDTH  per-stage write data
mem_ce_o  out  1  muxed chip enable
mem_we_o  out  1  muxed write enable
mem_addr_o  out  ADDR_WIDTH  muxed address
mem_width_o  out  4  muxed width
mem_data_o  out  DATA_WIDTH  muxed write data
busy_o  out  1  high while in RUN
cur_stage_o  out  SEL_WIDTH  index of the active stage
ready_o  out  1  packet finished (normal or aborted)
error_o  out  1  packet aborted by watchdog
err_stage_o  out  SEL_WIDTH  stage that timed out
cycle_cnt_o  out  32  cycles from start acceptance to completion

Behaviour:
- Reset (async, rst=0):
  - All outputs 0; state IDLE; sel=0; watchdog=0.
  - Reset in the middle of a packet aborts immediately; there is no error report.
- States and transitions:
  - IDLE:
    - Start is accepted when start_i=1.
    - On acceptance: latch skip mask and timeout; clear ready_o, error_o, err_stage_o and cycle_cnt_o.
    - k = lowest index with mask bit 0.
    - If such a k exists: stg_start_o = one-hot(k), sel = k, watchdog = 0, go to RUN.
    - If all stages are skipped: ready_o=1, go to DONE.
  - RUN, on each cycle:
    - cycle_cnt_o increments.
    - If stg_ready_i[sel]=1:
      - Clear stg_start_o[sel].
      - Find the next unskipped stage j > sel.
      - If j exists: set stg_start_o[j]=1 and sel=j on the same edge (zero-gap handoff), watchdog=0.
      - If j does not exist: ready_o=1, go to DONE.
    - Else, if timeout != 0 and watchdog == timeout-1:
      - stg_start_o = 0, error_o=1, err_stage_o=sel, ready_o=1, go to DONE.
    - Else: watchdog increments.
  - DONE:
    - ready_o, error_o, err_stage_o and cycle_cnt_o hold.
    - Go to IDLE when start_i=0. A start_i held high never retriggers.
    - ready_o stays high until the next start is accepted.
- Simultaneous events:
  - Ready and timeout in the same cycle: ready wins, no error.
  - stg_ready_i from non-selected stages is ignored.
- Memory mux (combinational from registered sel and state):
  - In RUN, outputs equal slice sel of the stg_mem_* inputs.
  - Outside RUN, mem_ce_o=0 and mem_we_o=0; addr/width/data are driven 0.
- busy_o = (state==RUN). cur_stage_o = sel.
- Latency: a stage sees start one cycle after acceptance or after its predecessor's ready.
- Widths:
  - The watchdog saturates at all ones; it never wraps.
  - cycle_cnt_o saturates at 2^32-1.

Test Plan:
- mask=000, timeout=0, each stage asserts ready 5 cycles after its start -> stg_start_o sequence 001,010,100 with zero-gap handoff; ready_o=1, error_o=0, cycle_cnt_o=15.
- mask=010 -> stage 1 is never started; mem_addr_o tracks stage 0 then stage 2; stage 1 memory activity never reaches the output.
- timeout=8, stage 1 never ready -> abort 8 cycles after stage-1 start; error_o=1, err_stage_o=1, stg_start_o=000, ready_o=1.
- timeout=4, stage 0 ready exactly when watchdog=3 -> no error; stage 1 starts next cycle.
- mask=111 -> ready_o=1 one cycle after start, no stg_start_o pulses; start_i held high in DONE causes no retrigger until it drops and reasserts.
- Reset pulse mid-RUN (stage 1 active) -> all outputs 0 asynchronously; the next start begins at stage 0.
